// File: rtl/ftf_pkg.sv
// ftf_pkg: constants, flag indices and stage bundles for float_to_fixed_pipe.
// Stage bundles are sized for the widest output (OUT_W = 32).
package ftf_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;
  localparam int SIG_W     = FP_MANT_W + 1;
  localparam int MAG_MAX_W = 33;

  localparam int FLAG_NAN     = 2;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_INEXACT = 0;

  typedef enum logic {
    RM_TRUNC = 1'b0,
    RM_RNE   = 1'b1
  } rmode_e;

  typedef struct packed {
    logic              valid;
    logic              sign;
    logic              nan;
    logic              inf;
    logic              flush_inx;
    logic [SIG_W-1:0]  sig;
    logic signed [9:0] shift;
`ifdef FTF_ROUND_NEAREST_EN
    rmode_e            rmode;
`endif
  } s1_t;

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic                 nan;
    logic                 inf;
    logic                 flush_inx;
    logic [MAG_MAX_W-1:0] mag;
    logic                 guard;
    logic                 sticky;
    logic                 ovf;
`ifdef FTF_ROUND_NEAREST_EN
    rmode_e               rmode;
`endif
  } s2_t;

endpackage

// File: rtl/ftf_align_shifter.sv
// ftf_align_shifter: bidirectional significand aligner for float_to_fixed_pipe.
// Produces integer magnitude, guard, sticky and shift-out overflow.
module ftf_align_shifter
  import ftf_pkg::*;
#(
  parameter int MW = 33
) (
  input  logic [SIG_W-1:0]  sig_i,
  input  logic signed [9:0] shift_i,
  output logic [MW-1:0]     mag_o,
  output logic              guard_o,
  output logic              sticky_o,
  output logic              ovf_o
);

  // 26 fraction bits below the binary point cover every useful right shift
  localparam int FW = 26;
  localparam int BW = FW + MW + SIG_W;
  localparam logic signed [9:0] SH_HI = 10'(MW);
  localparam logic signed [9:0] SH_LO = -10'sd26;

  logic [BW-1:0] vec;
  logic [6:0]    amt;

  always_comb begin
    amt      = 7'(shift_i - SH_LO);
    vec      = {{(BW-SIG_W){1'b0}}, sig_i} << amt;
    mag_o    = vec[FW+MW-1:FW];
    guard_o  = vec[FW-1];
    sticky_o = |vec[FW-2:0];
    ovf_o    = |vec[BW-1:FW+MW];
    if (shift_i >= SH_HI) begin
      mag_o    = '0;
      guard_o  = 1'b0;
      sticky_o = 1'b0;
      ovf_o    = |sig_i;
    end else if (shift_i <= SH_LO) begin
      mag_o    = '0;
      guard_o  = 1'b0;
      sticky_o = |sig_i;
      ovf_o    = 1'b0;
    end
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: 3-stage IEEE-754 single to saturating signed fixed point.
// Define FTF_ROUND_NEAREST_EN to honour in_rmode (RNE); otherwise truncate.
module float_to_fixed_pipe
  import ftf_pkg::*;
#(
  parameter int OUT_W        = 32,
  parameter int POS_W        = $clog2(OUT_W),
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_float,
  input  logic [POS_W-1:0] in_fixpointpos,
  input  logic             in_rmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_result,
  output logic [2:0]       out_flags
);

  localparam int MW = OUT_W + 1;
  localparam logic [MW:0] NEG_LIM = {3'b001, {(OUT_W-1){1'b0}}};
  localparam logic [MW:0] POS_LIM = {3'b000, {(OUT_W-1){1'b1}}};

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] res_d, res_q;
  logic [2:0]       flags_d, flags_q;
  logic             advance;

  assign advance    = !out_valid_q | out_ready;
  assign in_ready   = advance;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;

  logic [FP_EXP_W-1:0]  exp_f;
  logic [FP_MANT_W-1:0] man_f;
  logic is_nan, is_inf, is_flush, is_den;

  always_comb begin
    exp_f    = in_float[30:23];
    man_f    = in_float[22:0];
    is_nan   = (exp_f == 8'hFF) && (man_f != '0);
    is_inf   = (exp_f == 8'hFF) && (man_f == '0);
    is_flush = (exp_f == 8'h00) && (FLUSH_DENORM || man_f == '0);
    is_den   = (exp_f == 8'h00) && !FLUSH_DENORM && (man_f != '0);
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.sign  = in_float[31];
    s1_d.sig   = {1'b1, man_f};
    s1_d.shift = 10'(exp_f) + 10'(in_fixpointpos)
               - 10'(FP_BIAS + FP_MANT_W);
`ifdef FTF_ROUND_NEAREST_EN
    s1_d.rmode = rmode_e'(in_rmode);
`endif
    unique case (1'b1)
      is_nan: begin
        s1_d.nan = 1'b1;
        s1_d.sig = '0;
      end
      is_inf: s1_d.inf = 1'b1;
      is_flush: begin
        s1_d.sig       = '0;
        s1_d.flush_inx = |man_f;
      end
      // denormals: implicit bit 0, exponent fixed at -126
      is_den: begin
        s1_d.sig   = {1'b0, man_f};
        s1_d.shift = 10'd1 + 10'(in_fixpointpos)
                   - 10'(FP_BIAS + FP_MANT_W);
      end
      default: ;
    endcase
  end

`ifndef FTF_ROUND_NEAREST_EN
  logic unused_rmode;
  assign unused_rmode = in_rmode;
`endif

  logic [MW-1:0] sh_mag;
  logic sh_guard, sh_sticky, sh_ovf;

  ftf_align_shifter #(.MW(MW)) u_align (
    .sig_i   (s1_q.sig),
    .shift_i (s1_q.shift),
    .mag_o   (sh_mag),
    .guard_o (sh_guard),
    .sticky_o(sh_sticky),
    .ovf_o   (sh_ovf)
  );

  always_comb begin
    s2_d           = '0;
    s2_d.valid     = s1_q.valid;
    s2_d.sign      = s1_q.sign;
    s2_d.nan       = s1_q.nan;
    s2_d.inf       = s1_q.inf;
    s2_d.flush_inx = s1_q.flush_inx;
    s2_d.mag       = MAG_MAX_W'(sh_mag);
    s2_d.guard     = sh_guard;
    s2_d.sticky    = sh_sticky;
    s2_d.ovf       = sh_ovf;
`ifdef FTF_ROUND_NEAREST_EN
    s2_d.rmode     = s1_q.rmode;
`endif
  end

  logic [MW-1:0] mag;
  logic [MW:0]   mag_r;
  logic          big, ovf;
`ifdef FTF_ROUND_NEAREST_EN
  logic          inc;
`endif

  always_comb begin
    mag = s2_q.mag[MW-1:0];
`ifdef FTF_ROUND_NEAREST_EN
    inc   = (s2_q.rmode == RM_RNE) & s2_q.guard
          & (s2_q.sticky | mag[0]);
    mag_r = {1'b0, mag} + {{MW{1'b0}}, inc};
`else
    mag_r = {1'b0, mag};
`endif
    // negative side may reach exactly 2^(OUT_W-1)
    big   = s2_q.sign ? (mag_r > NEG_LIM) : (mag_r > POS_LIM);
    ovf   = !s2_q.nan & (s2_q.inf | s2_q.ovf | big);
    res_d = s2_q.sign ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
    if (ovf) begin
      res_d = s2_q.sign ? {1'b1, {(OUT_W-1){1'b0}}}
                        : {1'b0, {(OUT_W-1){1'b1}}};
    end
    if (s2_q.nan) res_d = '0;
    flags_d               = '0;
    flags_d[FLAG_NAN]     = s2_q.nan;
    flags_d[FLAG_OVF]     = ovf;
    flags_d[FLAG_INEXACT] = !s2_q.nan & !ovf
                          & (s2_q.flush_inx | s2_q.guard | s2_q.sticky);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= s2_q.valid;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// tb_float_to_fixed_pipe: scoreboard bench for float_to_fixed_pipe.
// Expected results queue on input acceptance and match on output transfer.
module tb_float_to_fixed_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready, in_rmode;
  logic        out_valid, out_ready;
  logic [31:0] in_float, out_result;
  logic [4:0]  in_fixpointpos;
  logic [2:0]  out_flags;

`ifdef FTF_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] f;
    logic [4:0]  pos;
    logic        rm;
    logic [31:0] r;
    logic [2:0]  fl;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  fl;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  float_to_fixed_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_float      (in_float),
    .in_fixpointpos(in_fixpointpos),
    .in_rmode      (in_rmode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  task automatic add(input logic [31:0] f, input int p, input logic rm,
                     input logic [31:0] r, input logic [2:0] fl);
    vq.push_back({f, 5'(p), rm, r, fl});
  endtask

  // drive head of vq for one cycle; called just after a negedge
  task automatic step(input logic ordy, output logic ov);
    in_valid = (vq.size() != 0);
    if (in_valid) begin
      in_float       = vq[0].f;
      in_fixpointpos = vq[0].pos;
      in_rmode       = vq[0].rm;
    end
    out_ready = ordy;
    #1;
    if (in_valid && in_ready) begin
      sb.push_back({vq[0].r, vq[0].fl});
      vq.delete(0);
    end
    ov = out_valid && out_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_float = '0;
    in_fixpointpos = '0;
    in_rmode = 1'b0;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold out_valid=%b want 0", out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
    checks++;
    if (out_result !== 32'h0 || out_flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_out res=%h flags=%b want 0 000",
               out_result, out_flags);
    end
  endtask

  task automatic test_basic();
    int cyc;
    int lat;
    logic ov;
    exp_t e;
    add(32'h3FC00000, 8, 1'b0, 32'h00000180, 3'b000);
    step(1'b1, ov);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency got=%0d want 3", lat);
    end
    add(32'hBFC00000, 8, 1'b0, 32'hFFFFFE80, 3'b000);
    add(32'h3FC00000, 0, 1'b0, 32'h00000001, 3'b001);
    cyc = 0;
    while ((vq.size() != 0 || sb.size() != 0) && cyc < 100) begin
      step(1'b1, ov);
      if (ov) begin
        checks++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
        if (out_result !== e.r || out_flags !== e.fl) begin
          errors++;
          $display("FAIL basic res=%h flags=%b want res=%h flags=%b",
                   out_result, out_flags, e.r, e.fl);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      checks++;
      errors++;
      $display("FAIL basic timeout");
    end
  endtask

  task automatic test_rounding();
    int cyc;
    logic ov;
    exp_t e;
    add(32'h40200000, 0, 1'b1, 32'h00000002, 3'b001);
    add(32'h40600000, 0, 1'b1, RNE ? 32'h4 : 32'h3, 3'b001);
    add(32'hC0200000, 0, 1'b1, 32'hFFFFFFFE, 3'b001);
    add(32'h40600000, 0, 1'b0, 32'h00000003, 3'b001);
    add(32'h40300000, 0, 1'b1, RNE ? 32'h3 : 32'h2, 3'b001);
    add(32'h40300000, 0, 1'b0, 32'h00000002, 3'b001);
    cyc = 0;
    while ((vq.size() != 0 || sb.size() != 0) && cyc < 100) begin
      step(1'b1, ov);
      if (ov) begin
        checks++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
        if (out_result !== e.r || out_flags !== e.fl) begin
          errors++;
          $display("FAIL round res=%h flags=%b want res=%h flags=%b",
                   out_result, out_flags, e.r, e.fl);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      checks++;
      errors++;
      $display("FAIL round timeout");
    end
  endtask

  task automatic test_saturation();
    int cyc;
    logic ov;
    exp_t e;
    add(32'h501502F9, 0, 1'b0, 32'h7FFFFFFF, 3'b010);
    add(32'hFF800000, 0, 1'b0, 32'h80000000, 3'b010);
    add(32'hCF000000, 0, 1'b0, 32'h80000000, 3'b000);
    add(32'h7F800000, 4, 1'b0, 32'h7FFFFFFF, 3'b010);
    add(32'h4F000000, 0, 1'b0, 32'h7FFFFFFF, 3'b010);
    cyc = 0;
    while ((vq.size() != 0 || sb.size() != 0) && cyc < 100) begin
      step(1'b1, ov);
      if (ov) begin
        checks++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
        if (out_result !== e.r || out_flags !== e.fl) begin
          errors++;
          $display("FAIL sat res=%h flags=%b want res=%h flags=%b",
                   out_result, out_flags, e.r, e.fl);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      checks++;
      errors++;
      $display("FAIL sat timeout");
    end
  endtask

  task automatic test_specials();
    int cyc;
    logic ov;
    exp_t e;
    add(32'h7FC00000, 0, 1'b0, 32'h00000000, 3'b100);
    add(32'h00000001, 8, 1'b0, 32'h00000000, 3'b001);
    add(32'h00000000, 8, 1'b0, 32'h00000000, 3'b000);
    add(32'h80000000, 3, 1'b0, 32'h00000000, 3'b000);
    cyc = 0;
    while ((vq.size() != 0 || sb.size() != 0) && cyc < 100) begin
      step(1'b1, ov);
      if (ov) begin
        checks++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
        if (out_result !== e.r || out_flags !== e.fl) begin
          errors++;
          $display("FAIL special res=%h flags=%b want res=%h flags=%b",
                   out_result, out_flags, e.r, e.fl);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      checks++;
      errors++;
      $display("FAIL special timeout");
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int got;
    logic ov;
    logic ordy;
    logic [31:0] want;
    exp_t e;
    add(32'h3F800000, 4, 1'b0, 32'h00000010, 3'b000);
    add(32'hBF800000, 4, 1'b0, 32'hFFFFFFF0, 3'b000);
    add(32'h3F000000, 1, 1'b0, 32'h00000001, 3'b000);
    add(32'h42C80000, 0, 1'b0, 32'h00000064, 3'b000);
    add(32'hBE800000, 3, 1'b0, 32'hFFFFFFFE, 3'b000);
    add(32'h3FC00000, 8, 1'b0, 32'h00000180, 3'b000);
    cyc = 0;
    got = 0;
    while ((vq.size() != 0 || sb.size() != 0) && cyc < 100) begin
      ordy = !(cyc >= 2 && cyc <= 6);
      step(ordy, ov);
      if (out_valid && !ordy) begin
        checks++;
        want = (sb.size() != 0) ? sb[0].r : 32'hxxxxxxxx;
        if (in_ready !== 1'b0 || sb.size() == 0 || out_result !== want) begin
          errors++;
          $display("FAIL stall in_ready=%b res=%h want in_ready=0 res=%h",
                   in_ready, out_result, want);
        end
      end
      if (ov) begin
        checks++;
        got++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
        if (out_result !== e.r || out_flags !== e.fl) begin
          errors++;
          $display("FAIL b2b res=%h flags=%b want res=%h flags=%b",
                   out_result, out_flags, e.r, e.fl);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 100 || got != 6) begin
      errors++;
      $display("FAIL b2b count got=%0d want 6", got);
    end
  endtask

  task automatic test_reset_inflight();
    logic ov;
    add(32'h3F800000, 4, 1'b0, 32'h00000010, 3'b000);
    add(32'h40200000, 0, 1'b0, 32'h00000002, 3'b001);
    add(32'hBFC00000, 8, 1'b0, 32'hFFFFFE80, 3'b000);
    repeat (3) begin
      step(1'b0, ov);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_pre out_valid=%b want 1", out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 3'b000) begin
      errors++;
      $display("FAIL inflight_async out_valid=%b res=%h flags=%b want 0 0 000",
               out_valid, out_result, out_flags);
    end
    sb.delete();
    vq.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL inflight_stale out_valid=%b in_ready=%b want 0 1",
                 out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_specials();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_to_fixed_pipe.md
Name: float_to_fixed_pipe

Overview:
Pipelined, parametrised IEEE-754 single-precision to signed two's-complement fixed-point converter with valid/ready handshake on both sides. It generalises the existing combinational converter:
- configurable output width
- per-sample binary-point position
- saturation instead of wrap
- round-nearest-even option
- NaN/Inf/denormal handling and status flags

Sits between float producers (datapath, host registers) and fixed-point consumers.

Parameters:
OUT_W, 32, output fixed-point width in bits (8..32)
POS_W, $clog2(OUT_W), width of fixpointpos field
FLUSH_DENORM, 1, 1 = denormal inputs produce 0; 0 = denormals converted exactly (implicit bit 0, exponent -126)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  converter accepts sample this cycle
in_float  in  32  IEEE-754 single
in_fixpointpos  in  POS_W  number of fractional bits in result (0..OUT_W-1)
in_rmode  in  1  0 = truncate toward zero, 1 = round-nearest-even
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  OUT_W  signed fixed-point result
out_flags  out  3  [2] nan, [1] overflow (saturated), [0] inexact

Behaviour:
- Reset: all stage valids 0, out_valid=0, out_result=0, out_flags=0, in_ready=1 after release. Reset mid-operation discards all in-flight samples.
- Result definition:
  - result = round(value * 2^fixpointpos), rounding on magnitude, then negated if sign=1.
  - Truncate = toward zero. RNE = ties to even on magnitude (symmetric).
- Pipeline: 3 stages, latency 3 cycles from accepted input to out_valid with out_ready held 1. Throughput 1/cycle.
  - S1 decode: unpack sign/exp/mant, form 24-bit significand (implicit 1), compute signed shift = exp - 127 + fixpointpos - 23 (10-bit signed).
  - S2 align: shift significand left (shift>0) or right (shift<0) into an OUT_W+1-bit magnitude plus guard bit and sticky OR. Right shift >= 26 yields magnitude 0, guard 0, sticky = (significand != 0).
  - S3 round/saturate/negate: apply rounding, detect overflow, two's-complement negate, register outputs.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - Every stage register loads only when advance=1 (global stall; bubbles not squeezed).
  - Input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
  - out_result and out_flags are held stable while out_valid & !out_ready.
- Special cases:
  - NaN (exp=255, mant!=0): result 0, nan=1, overflow=0, inexact=0.
  - ±Inf: saturate, overflow=1.
  - ±0: result 0, no flags.
  - Denormal with FLUSH_DENORM=1: result 0, inexact = (mant!=0).
- Overflow after rounding:
  - Positive magnitude > 2^(OUT_W-1)-1 → 0x7F..F.
  - Negative magnitude > 2^(OUT_W-1) → 0x80..0.
  - Overflow flag set in both cases; inexact is not additionally set.
  - -2^(OUT_W-1) exactly is legal, no flag.
  - Left shift that pushes any set bit beyond magnitude width → overflow.
- Inexact = guard | sticky (before rounding), for non-special, non-overflow cases.
- fixpointpos >= OUT_W is illegal input; behaviour unspecified.

Optional Feature:
- Macro: FTF_ROUND_NEAREST_EN.
- Defined: in_rmode honoured; RNE increments magnitude when guard & (sticky | lsb).
- Undefined: in_rmode ignored, always truncate toward zero, RNE adder removed; inexact flag still produced.

Decomposition:
- Package ftf_pkg:
  - constants FP_BIAS=127, FP_MANT_W=23, FP_EXP_W=8
  - flag bit indices FLAG_NAN/FLAG_OVF/FLAG_INEXACT
  - rmode typedef (RM_TRUNC=0, RM_RNE=1)
  - S1→S2 and S2→S3 stage struct typedefs
- Sub-module ftf_align_shifter: combinational bidirectional shifter producing magnitude, guard, sticky, overflow; instantiated in S2.

Test Plan:
- 0x3FC00000 (1.5), pos=8 → 0x00000180, flags 0; 0xBFC00000 (-1.5), pos=8 → 0xFFFFFE80, latency exactly 3 cycles.
- RNE, pos=0: 2.5 (0x40200000) → 2, 3.5 (0x40600000) → 4, -2.5 → 0xFFFFFFFE; inexact=1 for all. Truncate: 3.5 → 3.
- 1e10 (0x501502F9), pos=0, OUT_W=32 → 0x7FFFFFFF, overflow=1. -Inf → 0x80000000, overflow=1. -2^31 (0xCF000000) → 0x80000000, no flags.
- 0x7FC00000 (NaN) → 0, nan=1. Denormal 0x00000001 → 0, inexact=1. +0 → 0, no flags.
- Back-to-back stream of 6 values with out_ready low cycles 2-6: in_ready=0 while stalled, outputs held stable, no loss or reorder, all 6 emerge in order.
- Assert rst low with 3 samples in flight: out_valid=0 immediately (async), no stale outputs after reset release.
